// File: rtl/posit_pkg.sv
// Shared posit definitions: default geometry, special encodings and the
// decoded tuple exchanged between the decode and encode paths.
package posit_pkg;

  localparam int POSIT_BITS   = 32;
  localparam int POSIT_ES     = 2;
  localparam int POSIT_FRAC_W = 32;

  // Special encodings for any word width up to 64 bits (callers slice)
  function automatic logic [63:0] posit_maxpos(input int bits);
    return (64'd1 << (bits - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] posit_minpos(input int bits);
    return (bits > 0) ? 64'd1 : 64'd0;
  endfunction

  function automatic logic [63:0] posit_nar(input int bits);
    return 64'd1 << (bits - 1);
  endfunction

  function automatic logic [63:0] posit_zero(input int bits);
    return 64'd0 << bits;
  endfunction

  localparam logic [POSIT_BITS-1:0] POSIT_MAXPOS = POSIT_BITS'(posit_maxpos(POSIT_BITS));
  localparam logic [POSIT_BITS-1:0] POSIT_MINPOS = POSIT_BITS'(posit_minpos(POSIT_BITS));
  localparam logic [POSIT_BITS-1:0] POSIT_NAR    = POSIT_BITS'(posit_nar(POSIT_BITS));
  localparam logic [POSIT_BITS-1:0] POSIT_ZERO   = POSIT_BITS'(posit_zero(POSIT_BITS));

  typedef struct packed {
    logic                    sign;
    logic [POSIT_BITS-1:0]   seed;
    logic [POSIT_ES-1:0]     exp;
    logic [POSIT_FRAC_W-1:0] frac;
    logic                    sticky;
    logic                    zero;
    logic                    nar;
  } posit_tuple_t;

endpackage

// File: rtl/posit_encoder_right_shifter.sv
// Logical right shifter that also reports whether any set bit fell off the
// bottom, so the caller can fold it into a rounding sticky.
module right_shifter #(
  parameter int W  = 64,
  parameter int SW = 6
) (
  input  logic [W-1:0]  data,
  input  logic [SW-1:0] shamt,
  output logic [W-1:0]  shifted,
  output logic          sticky
);

  logic [W-1:0] lost_mask;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_mask
      assign lost_mask[gi] = (32'(shamt) > gi);
    end
  endgenerate

  assign shifted = data >> shamt;
  assign sticky  = |(data & lost_mask);

endmodule

// File: rtl/posit_encoder.sv
// Three-stage posit encoder: regime build, pack/round, sign/specials.
// Elastic ready/valid pipeline, one word per cycle when unstalled.
module posit_encoder
  import posit_pkg::*;
#(
  parameter int BITS   = POSIT_BITS,
  parameter int ES     = POSIT_ES,
  parameter int FRAC_W = POSIT_FRAC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [BITS-1:0]   in_seed,
  input  logic [ES-1:0]     in_exp,
  input  logic [FRAC_W-1:0] in_frac,
  input  logic              in_sticky,
  input  logic              in_zero,
  input  logic              in_nar,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BITS-1:0]   out_posit
);

  localparam int SW   = $clog2(BITS);
  localparam int TAIL = ES + FRAC_W;
  localparam int VW   = BITS - 1 + TAIL;

  localparam logic [BITS-1:0] MAXPOS = BITS'(posit_maxpos(BITS));
  localparam logic [BITS-1:0] MINPOS = BITS'(posit_minpos(BITS));
  localparam logic [BITS-1:0] NAR    = BITS'(posit_nar(BITS));
  localparam logic [BITS-1:0] ZERO   = BITS'(posit_zero(BITS));

  localparam logic signed [BITS-1:0] K_MAX = BITS'(BITS - 2);
  localparam logic signed [BITS-1:0] K_MIN = BITS'(-(BITS - 1));
  localparam logic [BITS-2:0] REGIME_ONES = '1;
  localparam logic [BITS-2:0] REGIME_TOP  = {1'b1, {(BITS-2){1'b0}}};

  logic s1_valid_reg, s2_valid_reg, s3_valid_reg;
  logic s1_en, s2_en, s3_en;

  assign s3_en    = !s3_valid_reg || out_ready;
  assign s2_en    = !s2_valid_reg || s3_en;
  assign s1_en    = !s1_valid_reg || s2_en;
  assign in_ready = s1_en;

  // S1: regime length and left-aligned run pattern
  logic          k_neg;
  logic [SW-1:0] rl_next, run_shift;
  logic [BITS-2:0] pattern_next;

  assign k_neg        = in_seed[BITS-1];
  assign rl_next      = k_neg ? (SW'(1) - in_seed[SW-1:0]) : (in_seed[SW-1:0] + SW'(2));
  assign run_shift    = rl_next - SW'(1);
  assign pattern_next = k_neg ? (REGIME_TOP >> run_shift) : ~(REGIME_ONES >> run_shift);

  logic              s1_sign_reg, s1_sticky_reg, s1_zero_reg, s1_nar_reg;
  logic              s1_sat_max_reg, s1_sat_min_reg;
  logic [ES-1:0]     s1_exp_reg;
  logic [FRAC_W-1:0] s1_frac_reg;
  logic [SW-1:0]     s1_rl_reg;
  logic [BITS-2:0]   s1_pattern_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg   <= 1'b0;
      s1_sign_reg    <= 1'b0;
      s1_sticky_reg  <= 1'b0;
      s1_zero_reg    <= 1'b0;
      s1_nar_reg     <= 1'b0;
      s1_sat_max_reg <= 1'b0;
      s1_sat_min_reg <= 1'b0;
      s1_exp_reg     <= '0;
      s1_frac_reg    <= '0;
      s1_rl_reg      <= '0;
      s1_pattern_reg <= '0;
    end else if (s1_en) begin
      s1_valid_reg   <= in_valid;
      s1_sign_reg    <= in_sign;
      s1_sticky_reg  <= in_sticky;
      s1_zero_reg    <= in_zero;
      s1_nar_reg     <= in_nar;
      s1_sat_max_reg <= ($signed(in_seed) >= K_MAX);
      s1_sat_min_reg <= ($signed(in_seed) <= K_MIN);
      s1_exp_reg     <= in_exp;
      s1_frac_reg    <= in_frac;
      s1_rl_reg      <= rl_next;
      s1_pattern_reg <= pattern_next;
    end
  end

  // S2: slide exp/frac under the regime, then round to nearest even
  logic [VW-1:0]   shift_in, shifted;
  logic            shift_sticky, guard_bit, rest_sticky, round_up;
  logic [BITS-2:0] kept;
  logic [BITS-1:0] rounded, pos_next;

  assign shift_in = {s1_exp_reg, s1_frac_reg, {(BITS-1){1'b0}}};

  right_shifter #(.W(VW), .SW(SW)) u_right_shifter (
    .data    (shift_in),
    .shamt   (s1_rl_reg),
    .shifted (shifted),
    .sticky  (shift_sticky)
  );

  assign kept        = shifted[VW-1 -: BITS-1] | s1_pattern_reg;
  assign guard_bit   = shifted[TAIL-1];
  assign rest_sticky = (|shifted[TAIL-2:0]) | shift_sticky | s1_sticky_reg;
  assign round_up    = guard_bit & (kept[0] | rest_sticky);
  assign rounded     = {1'b0, kept} + BITS'(round_up);

  always_comb begin
    pos_next = rounded;
    if (rounded[BITS-1])     pos_next = MAXPOS;
    else if (rounded == '0)  pos_next = MINPOS;
    if (s1_sat_max_reg)      pos_next = MAXPOS;
    else if (s1_sat_min_reg) pos_next = MINPOS;
  end

  logic            s2_sign_reg, s2_zero_reg, s2_nar_reg;
  logic [BITS-1:0] s2_pos_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg <= 1'b0;
      s2_sign_reg  <= 1'b0;
      s2_zero_reg  <= 1'b0;
      s2_nar_reg   <= 1'b0;
      s2_pos_reg   <= '0;
    end else if (s2_en) begin
      s2_valid_reg <= s1_valid_reg;
      s2_sign_reg  <= s1_sign_reg;
      s2_zero_reg  <= s1_zero_reg;
      s2_nar_reg   <= s1_nar_reg;
      s2_pos_reg   <= pos_next;
    end
  end

  // S3: negate and apply the special encodings, NaR winning over zero
  logic [BITS-1:0] out_next;
  logic [BITS-1:0] out_posit_reg;

  always_comb begin
    out_next = s2_sign_reg ? (-s2_pos_reg) : s2_pos_reg;
    if (s2_nar_reg)       out_next = NAR;
    else if (s2_zero_reg) out_next = ZERO;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid_reg  <= 1'b0;
      out_posit_reg <= '0;
    end else if (s3_en) begin
      s3_valid_reg  <= s2_valid_reg;
      out_posit_reg <= out_next;
    end
  end

  assign out_valid = s3_valid_reg;
  assign out_posit = out_posit_reg;

endmodule

// File: tb/tb_posit_encoder.sv
// Bench for posit_encoder: directed test-plan cases, backpressure, async
// reset, then randomized traffic against a value-level reference encoder.
module tb_posit_encoder;
  import posit_pkg::*;

  localparam int BITS   = 32;
  localparam int ES     = 2;
  localparam int FRAC_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_sign = 1'b0;
  logic [BITS-1:0]   in_seed = '0;
  logic [ES-1:0]     in_exp = '0;
  logic [FRAC_W-1:0] in_frac = '0;
  logic              in_sticky = 1'b0;
  logic              in_zero = 1'b0;
  logic              in_nar = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [BITS-1:0]   out_posit;

  always #5 clk = ~clk;

  posit_encoder #(.BITS(BITS), .ES(ES), .FRAC_W(FRAC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_seed   (in_seed),
    .in_exp    (in_exp),
    .in_frac   (in_frac),
    .in_sticky (in_sticky),
    .in_zero   (in_zero),
    .in_nar    (in_nar),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_posit (out_posit)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_out = 0;
  logic [BITS-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: observed %h, expected %h", tag, obs, expv);
    end
  endtask

  // Reference: build the full bit string as an integer, keep the top BITS-1
  // bits and round by comparing the remainder against one half ulp.
  function automatic logic [31:0] ref_encode(input posit_tuple_t t);
    int k, rl, d;
    logic [127:0] r, full, kept, rem, half;
    logic [31:0] mag;
    k = $signed(t.seed);
    if (t.nar)  return 32'h8000_0000;
    if (t.zero) return 32'h0000_0000;
    if (k >= BITS - 2) mag = 32'h7FFF_FFFF;
    else if (k <= -(BITS - 1)) mag = 32'h0000_0001;
    else begin
      rl   = (k >= 0) ? k + 2 : 1 - k;
      r    = (k >= 0) ? ((128'd1 << (k + 2)) - 128'd2) : 128'd1;
      full = (r << (ES + FRAC_W)) | (128'(t.exp) << FRAC_W) | 128'(t.frac);
      d    = rl + ES + FRAC_W - (BITS - 1);
      kept = full >> d;
      rem  = full & ((128'd1 << d) - 128'd1);
      half = 128'd1 << (d - 1);
      if (rem > half || (rem == half && (t.sticky || kept[0]))) kept = kept + 128'd1;
      if (kept > 128'h7FFF_FFFF) kept = 128'h7FFF_FFFF;
      if (kept == 128'd0) kept = 128'd1;
      mag = kept[31:0];
    end
    return t.sign ? (-mag) : mag;
  endfunction

  function automatic posit_tuple_t mk(input bit s, input int k, input logic [ES-1:0] e,
                                      input logic [FRAC_W-1:0] f, input bit st,
                                      input bit z, input bit n);
    posit_tuple_t t;
    t.sign = s; t.seed = BITS'(k); t.exp = e; t.frac = f;
    t.sticky = st; t.zero = z; t.nar = n;
    return t;
  endfunction

  task automatic drive(input posit_tuple_t t);
    in_sign = t.sign; in_seed = t.seed; in_exp = t.exp; in_frac = t.frac;
    in_sticky = t.sticky; in_zero = t.zero; in_nar = t.nar;
  endtask

  // Called just after a rising edge; returns just after the accepting edge
  task automatic send(input posit_tuple_t t, input logic [31:0] expv);
    drive(t);
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(expv);
        $display("in  seed=%0d sign=%0b exp=%0d frac=%h sticky=%0b zero=%0b nar=%0b -> %h",
                 $signed(t.seed), t.sign, t.exp, t.frac, t.sticky, t.zero, t.nar, expv);
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    check_eq("in_ready_timeout", {31'b0, in_ready}, 32'd1);
  endtask

  task automatic send_lat(input posit_tuple_t t, input logic [31:0] expv, input string tag);
    int lat;
    send(t, expv);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq(tag, 32'(lat), 32'd3);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Output scoreboard and hold-while-stalled checks
  logic            prev_stall = 1'b0;
  logic [BITS-1:0] prev_posit = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("hold_valid", {31'b0, out_valid}, 32'd1);
        check_eq("hold_posit", out_posit, prev_posit);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check_eq("unexpected_out_valid", {31'b0, out_valid}, 32'd0);
        else check_eq("out_posit", out_posit, exp_q.pop_front());
        $display("out %0d: %h", n_out, out_posit);
        n_out++;
      end
      prev_stall = out_valid && !out_ready;
      prev_posit = out_posit;
    end
  end

  posit_tuple_t dir_t[11];
  logic [31:0]  dir_e[11];
  bit           rand_done;
  int           n_out0;
  posit_tuple_t t;

  initial begin
    dir_t[0]  = mk(0, -1, 0, 32'h0, 0, 0, 0);          dir_e[0]  = 32'h2000_0000;
    dir_t[1]  = mk(0, 1, 0, 32'h0, 0, 0, 0);           dir_e[1]  = 32'h6000_0000;
    dir_t[2]  = mk(1, 0, 0, 32'h0, 0, 0, 0);           dir_e[2]  = 32'hC000_0000;
    dir_t[3]  = mk(0, 0, 0, 32'hFFFF_FFFF, 0, 0, 0);   dir_e[3]  = 32'h4800_0000;
    dir_t[4]  = mk(0, 0, 0, 32'h0000_0010, 0, 0, 0);   dir_e[4]  = 32'h4000_0000;
    dir_t[5]  = mk(0, 40, 0, 32'h0, 0, 0, 0);          dir_e[5]  = 32'h7FFF_FFFF;
    dir_t[6]  = mk(0, -40, 0, 32'h0, 0, 0, 0);         dir_e[6]  = 32'h0000_0001;
    dir_t[7]  = mk(0, 3, 1, 32'h1234_5678, 0, 0, 1);   dir_e[7]  = 32'h8000_0000;
    dir_t[8]  = mk(1, 3, 1, 32'h1234_5678, 0, 1, 0);   dir_e[8]  = 32'h0000_0000;
    dir_t[9]  = mk(1, 0, 0, 32'h0, 0, 1, 1);           dir_e[9]  = 32'h8000_0000;
    dir_t[10] = mk(0, 0, 0, 32'h0000_0010, 1, 0, 0);   dir_e[10] = 32'h4000_0001;

    // Reset state
    #12;
    check_eq("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("reset_out_posit", out_posit, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("reset_in_ready", {31'b0, in_ready}, 32'd1);

    // Directed cases, first one also measures latency
    out_ready = 1'b1;
    send_lat(mk(0, 0, 0, 32'h0, 0, 0, 0), 32'h4000_0000, "latency");
    idle(2);
    for (int i = 0; i < 11; i++) send(dir_t[i], dir_e[i]);
    idle(6);

    // Backpressure: only three fit while the output is stalled
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(mk(0, i, 0, 32'h0, 0, 0, 0), 32'h8000_0000 - (32'h4000_0000 >> i));
    drive(mk(0, 3, 0, 32'h0, 0, 0, 0));
    repeat (4) begin
      @(negedge clk);
      check_eq("bp_in_ready", {31'b0, in_ready}, 32'd0);
      check_eq("bp_out_posit", out_posit, 32'h4000_0000);
    end
    @(posedge clk); #1;
    n_out0 = n_out;
    out_ready = 1'b1;
    send(mk(0, 3, 0, 32'h0, 0, 0, 0), 32'h7800_0000);
    send(mk(0, 4, 0, 32'h0, 0, 0, 0), 32'h7C00_0000);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("bp_throughput", 32'(n_out - n_out0), 32'd5);
    idle(4);

    // Asynchronous reset with three items in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(mk(0, i, 0, 32'h0, 0, 0, 0), 32'h8000_0000 - (32'h4000_0000 >> i));
    in_valid = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst_async_posit", out_posit, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check_eq("rst_no_stale", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b1;
    send_lat(mk(0, 1, 0, 32'h0, 0, 0, 0), 32'h6000_0000, "rst_latency");
    idle(10);
    check_eq("rst_drained", 32'(exp_q.size()), 32'd0);

    // Randomized traffic with random output stalls
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
          t.sign   = 1'($urandom);
          t.seed   = ($urandom_range(0, 15) == 0) ? BITS'($urandom)
                                                  : BITS'(int'($urandom_range(0, 68)) - 34);
          t.exp    = ES'($urandom);
          t.frac   = ($urandom_range(0, 7) == 0) ? {FRAC_W{1'b1}} : FRAC_W'($urandom);
          t.sticky = 1'($urandom);
          t.zero   = ($urandom_range(0, 31) == 0);
          t.nar    = ($urandom_range(0, 31) == 0);
          send(t, ref_encode(t));
        end
        in_valid = 1'b0;
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    idle(20);
    check_eq("rand_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/posit_encoder.md
Name: posit_encoder

Overview:
- Pipelined posit encoder: the inverse of the decode path's regime/seed extraction.
- Takes a decoded tuple (sign, signed regime seed, exponent, fraction, zero/NaR flags) and packs it into a BITS-wide posit word.
- Steps: builds the run-length regime field, appends exponent and fraction, applies round-to-nearest-even, then two's-complements for negative values.
- Sits at the output of the posit arithmetic units; ready/valid handshake on both sides.

Parameters:
- BITS, 32: posit word width (>= 8).
- ES, 2: exponent field width.
- FRAC_W, 32: input fraction width, hidden bit excluded, MSB-aligned.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input tuple valid.
- in_ready  output  1  encoder can accept the tuple this cycle.
- in_sign  input  1  1 = negative.
- in_seed  input  BITS  signed regime value k (same encoding as the decoder's seed output).
- in_exp  input  ES  exponent field.
- in_frac  input  FRAC_W  fraction bits below the hidden 1.
- in_sticky  input  1  OR of any discarded bits below in_frac.
- in_zero  input  1  encode zero; overrides all other fields.
- in_nar  input  1  encode NaR; overrides in_zero.
- out_valid  output  1  out_posit valid.
- out_ready  input  1  consumer accepts out_posit.
- out_posit  output  BITS  encoded posit.

Behaviour:
- Reset (async, rst_n=0): all stage valid bits = 0, out_valid = 0, out_posit = 0, in_ready = 1 one cycle after release. In-flight data is discarded; no partial outputs after reset.
- Pipeline: 3 registered stages S1 -> S2 -> S3. Latency is 3 cycles from input handshake to out_valid when unstalled. Throughput is 1 per cycle.
- Handshake:
  - A transfer occurs when valid & ready.
  - Stage n advances when it is empty or stage n+1 advances. S3 advances when out_ready=1.
  - in_ready = !S1_valid | S1_advance. This combinational ready chain is permitted.
  - out_posit and out_valid hold stable while out_valid & !out_ready.
  - Ordering is preserved; no drops, no duplicates.
- S1, regime build:
  - k >= 0: (k+1) ones followed by one zero.
  - k < 0: (-k) zeros followed by one one.
  - Regime length rl = k+2 or -k+1.
  - Compute rl, the regime pattern, and saturation flags:
    - k >= BITS-2 -> SAT_MAX.
    - k <= -(BITS-1) -> SAT_MIN.
  - Register sign, exp, frac, sticky, zero and NaR alongside.
- S2, pack and round:
  - Form {regime, exp, frac} as a (BITS-1+ES+FRAC_W)-bit vector. Right-shift so the regime MSB lands at bit BITS-2.
  - Guard = first dropped bit. Sticky = OR of the remaining dropped bits | in_sticky.
  - Round-to-nearest-even: increment when guard & (lsb | sticky).
  - The increment may carry into the exp and regime fields; this is correct posit rounding.
  - The result is clamped:
    - never exceeds maxpos 0x7FF..F;
    - a nonzero value never rounds to 0, giving minpos 0x00..01.
  - SAT_MAX forces maxpos. SAT_MIN forces minpos.
- S3, sign and specials:
  - If sign=1, out = two's complement of the positive word.
  - in_nar -> 0x80..0. in_zero -> 0x00..0; sign is ignored.
- Widths:
  - Shift amount is clog2(BITS) bits.
  - Exponent/fraction bits that fall below bit 0 contribute only to guard/sticky.
  - When rl = BITS-1, no exp or fraction bits survive.

Decomposition:
- Package posit_pkg holds:
  - default BITS/ES;
  - constants POSIT_MAXPOS, POSIT_MINPOS, POSIT_NAR, POSIT_ZERO as functions of BITS;
  - a packed struct posit_tuple_t (sign, seed, exp, frac, sticky, zero, nar), shared with the decoder side.
- One sub-module, right_shifter: the counterpart of the existing left_shifter. It takes a data vector and shift amount and returns the shifted vector plus a sticky OR of the bits shifted out. It is used in S2.

Test Plan (BITS=32, ES=2):
- seed=0, exp=0, frac=0, sign=0 -> 0x40000000 three cycles after handshake.
- seed=-1, exp=0, frac=0 -> 0x20000000. seed=1 -> 0x60000000. seed=0 with sign=1 -> 0xC0000000.
- Round-up carry: seed=0, exp=0, frac=0xFFFFFFFF, sticky=0 -> 0x48000000. Tie case frac=0x00000010, sticky=0 -> 0x40000000 (even, no increment).
- Saturation and specials:
  - seed=40 -> 0x7FFFFFFF.
  - seed=-40 -> 0x00000001.
  - in_nar=1 -> 0x80000000.
  - in_zero=1 with sign=1 -> 0x00000000.
- Backpressure: out_ready=0 while issuing 5 back-to-back inputs (seed 0..4). in_ready deasserts after exactly 3 are accepted and out_posit is stable. Then release out_ready -> 0x40000000, 0x60000000, 0x70000000, 0x78000000, 0x7C000000 in order, 1 per cycle.
- Reset mid-stream: assert rst_n=0 with 3 items in flight -> out_valid falls to 0 immediately without waiting for clk. After release, no stale items appear and the next input emerges after 3 cycles.
